// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the parametrised multiply-accumulate block.
package mac_pkg;

  localparam int MAX_W = 128;

  // Control flags that travel alongside the registered product.
  typedef struct packed {
    logic load;
    logic sub;
    logic valid;
  } mode_t;

  function automatic bit width_ok(input int a_w, input int b_w, input int acc_w);
    return acc_w >= a_w + b_w;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int w, input bit is_signed);
    logic [MAX_W-1:0] one;
    one = 1;
    return is_signed ? (one << (w - 1)) - one : (one << w) - one;
  endfunction

  // Signed minimum is the lone sign bit once truncated to w bits.
  function automatic logic [MAX_W-1:0] sat_min(input int w, input bit is_signed);
    logic [MAX_W-1:0] one;
    one = 1;
    return is_signed ? (one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Product register stage: full-width a*b with the load/sub/valid flags riding along.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int A_W    = 20,
  parameter int B_W    = 18,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               valid_in,
  input  logic               load,
  input  logic               sub,
  output logic [A_W+B_W-1:0] p,
  output mode_t              mode
);

  localparam int P_W = A_W + B_W;

  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] b_ext;

  // Extending both operands to the product width makes the low P_W bits exact in either mode.
  assign a_ext = {{B_W{(SIGNED != 0) && a[A_W-1]}}, a};
  assign b_ext = {{A_W{(SIGNED != 0) && b[B_W-1]}}, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      p    <= '0;
      mode <= '0;
    end else begin
      mode <= valid_in ? '{load: load, sub: sub, valid: 1'b1} : '0;
      if (valid_in) begin
        p <= a_ext * b_ext;
      end
    end
  end

endmodule

// File: rtl/mac_accum_param.sv
// Parametrised pipelined MAC: product stage, accumulate with overflow/saturation, optional output register.
module mac_accum_param
  import mac_pkg::*;
#(
  parameter int A_W      = 20,
  parameter int B_W      = 18,
  parameter int ACC_W    = 38,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  parameter int OUT_REG  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             valid_in,
  input  logic             load,
  input  logic             sub,
  output logic [ACC_W-1:0] z_out,
  output logic             valid_out,
  output logic             overflow
);

  localparam int P_W = A_W + B_W;
  localparam int X_W = ACC_W + 2;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

  generate
    if (!width_ok(A_W, B_W, ACC_W)) begin : g_width_err
      $error("mac_accum_param: ACC_W must be at least A_W+B_W");
    end
  endgenerate

  logic [P_W-1:0]   p;
  mode_t            mode;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             acc_ovf;
  logic [X_W-1:0]   base_x;
  logic [X_W-1:0]   term_x;
  logic [X_W-1:0]   res_x;
  logic             ovf_now;
  logic [ACC_W-1:0] acc_next;

  mac_mult_stage #(
    .A_W    (A_W),
    .B_W    (B_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .valid_in (valid_in),
    .load     (load),
    .sub      (sub),
    .p        (p),
    .mode     (mode)
  );

  // Two guard bits hold the exact result; any spill past ACC_W (or past the sign bit) is overflow,
  // and the top guard bit says which way to clamp.
  always_comb begin
    base_x = mode.load ? '0 : {{2{(SIGNED != 0) && acc[ACC_W-1]}}, acc};
    term_x = {{(X_W-P_W){(SIGNED != 0) && p[P_W-1]}}, p};
    res_x  = mode.sub ? base_x - term_x : base_x + term_x;
    if (SIGNED != 0) begin
      ovf_now = (res_x[X_W-1:ACC_W-1] != '0) && (res_x[X_W-1:ACC_W-1] != '1);
    end else begin
      ovf_now = res_x[X_W-1:ACC_W] != '0;
    end
    acc_next = res_x[ACC_W-1:0];
    if ((SATURATE != 0) && ovf_now) begin
      acc_next = res_x[X_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      acc_ovf   <= 1'b0;
    end else begin
      acc_valid <= mode.valid;
      if (mode.valid) begin
        acc <= acc_next;
        if (ovf_now) begin
          acc_ovf <= 1'b1;
        end else if (mode.load) begin
          acc_ovf <= 1'b0;
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          z_out     <= '0;
          valid_out <= 1'b0;
          overflow  <= 1'b0;
        end else begin
          z_out     <= acc;
          valid_out <= acc_valid;
          overflow  <= acc_ovf;
        end
      end
    end else begin : g_out_comb
      assign z_out     = acc;
      assign valid_out = acc_valid;
      assign overflow  = acc_ovf;
    end
  endgenerate

endmodule

// File: tb/tb_mac_accum_param.sv
// Bench for mac_accum_param: six parameter variants driven in parallel, checked against an integer model.
module tb_mac_accum_param;

  localparam int NCFG = 6;
  localparam int CFG_SIGNED [NCFG] = '{0, 0, 1, 1, 0, 1};
  localparam int CFG_SAT    [NCFG] = '{0, 1, 0, 1, 0, 0};
  localparam int CFG_OREG   [NCFG] = '{1, 1, 1, 1, 0, 0};
  localparam longint MOD = 64'sd1 << 38;

  logic        clk;
  logic        reset;
  logic [19:0] a;
  logic [17:0] b;
  logic        valid_in;
  logic        load;
  logic        sub;
  logic [37:0] z [NCFG];
  logic        v [NCFG];
  logic        o [NCFG];

  int errors = 0;
  int checks = 0;

  longint      acc_m [NCFG];
  bit          ovf_m [NCFG];
  logic [37:0] hz    [NCFG][2];
  bit          hv    [NCFG][2];
  bit          ho    [NCFG][2];
  logic [37:0] exp_z [NCFG];
  bit          exp_v [NCFG];
  bit          exp_o [NCFG];
  bit          chk_en = 1'b0;

  generate
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
      mac_accum_param #(
        .A_W      (20),
        .B_W      (18),
        .ACC_W    (38),
        .SIGNED   (CFG_SIGNED[g]),
        .SATURATE (CFG_SAT[g]),
        .OUT_REG  (CFG_OREG[g])
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .load      (load),
        .sub       (sub),
        .z_out     (z[g]),
        .valid_out (v[g]),
        .overflow  (o[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interpret the low w bits of raw as an unsigned or two's-complement integer.
  function automatic longint to_int(input logic [63:0] raw, input int w, input bit s);
    logic [63:0] m;
    longint r;
    m = raw & ((64'd1 << w) - 64'd1);
    r = longint'(m);
    if (s && m[w-1]) r = r - longint'(64'd1 << w);
    return r;
  endfunction

  // Exact-integer accumulate, then classify against the representable range.
  function automatic void model_step(input int c, input logic [19:0] av, input logic [17:0] bv,
                                     input bit ld, input bit sb);
    longint prod, res, lo, hi;
    bit s, ovf;
    s    = CFG_SIGNED[c] != 0;
    prod = to_int(64'(av), 20, s) * to_int(64'(bv), 18, s);
    res  = (ld ? 64'sd0 : acc_m[c]) + (sb ? -prod : prod);
    lo   = s ? -(MOD / 2) : 64'sd0;
    hi   = s ? (MOD / 2) - 1 : MOD - 1;
    ovf  = (res < lo) || (res > hi);
    if (ovf && (CFG_SAT[c] != 0)) res = (res < lo) ? lo : hi;
    else if (ovf) res = to_int(64'(res), 38, s);
    acc_m[c] = res;
    if (ovf) ovf_m[c] = 1'b1;
    else if (ld) ovf_m[c] = 1'b0;
  endfunction

  // Results appear one or two edges after the input edge; reset wipes everything in flight.
  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      if (reset) begin
        acc_m[c] = 0;
        ovf_m[c] = 1'b0;
        for (int k = 0; k < 2; k++) begin
          hz[c][k] = '0;
          hv[c][k] = 1'b0;
          ho[c][k] = 1'b0;
        end
      end
      exp_z[c] = (CFG_OREG[c] != 0) ? hz[c][1] : hz[c][0];
      exp_v[c] = (CFG_OREG[c] != 0) ? hv[c][1] : hv[c][0];
      exp_o[c] = (CFG_OREG[c] != 0) ? ho[c][1] : ho[c][0];
      hz[c][1] = hz[c][0];
      hv[c][1] = hv[c][0];
      ho[c][1] = ho[c][0];
      if (!reset && valid_in) model_step(c, a, b, load, sub);
      hz[c][0] = 38'(acc_m[c]);
      hv[c][0] = !reset && valid_in;
      ho[c][0] = ovf_m[c];
    end
    if (reset) chk_en = 1'b1;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCFG; c++) begin
        check_output($sformatf("cfg%0d z_out", c), 64'(z[c]), 64'(exp_z[c]));
        check_output($sformatf("cfg%0d valid_out", c), 64'(v[c]), 64'(exp_v[c]));
        check_output($sformatf("cfg%0d overflow", c), 64'(o[c]), 64'(exp_o[c]));
      end
    end
  end

  task automatic apply_stimulus(input logic rst, input logic vin, input logic ld, input logic sb,
                                input logic [19:0] av, input logic [17:0] bv);
    reset    = rst;
    valid_in = vin;
    load     = ld;
    sub      = sb;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [19:0] ra;
    logic [17:0] rb;
    reset = 1'b1; valid_in = 1'b0; load = 1'b0; sub = 1'b0; a = '0; b = '0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check_output("reset z_out", 64'(z[0]), 64'd0);
    check_output("reset valid_out", 64'(v[0]), 64'd0);

    // Largest unsigned product loaded, then accumulated until it wraps.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 20'h7FFFF, 18'h1FFFF);
    idle(1);
    check_output("load z one cycle early", 64'(z[4]), 64'd68718821377);
    check_output("load valid one cycle early", 64'(v[4]), 64'd1);
    idle(1);
    check_output("load z", 64'(z[0]), 64'd68718821377);
    check_output("load valid", 64'(v[0]), 64'd1);
    check_output("load overflow", 64'(o[0]), 64'd0);
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 20'h7FFFF, 18'h1FFFF);
    idle(2);
    check_output("four terms z", 64'(z[0]), 64'd274875285508);
    check_output("four terms overflow", 64'(o[0]), 64'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 20'h7FFFF, 18'h1FFFF);
    idle(2);
    check_output("wrap z", 64'(z[0]), 64'd68716199941);
    check_output("wrap overflow", 64'(o[0]), 64'd1);
    check_output("saturate z", 64'(z[1]), 64'd274877906943);
    check_output("saturate overflow", 64'(o[1]), 64'd1);

    // Reset lands while a product is in flight; the input presented with reset is dropped.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 20'd7, 18'd7);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 20'd9, 18'd9);
    check_output("flush z", 64'(z[0]), 64'd0);
    check_output("flush overflow", 64'(o[0]), 64'd0);
    idle(1);
    check_output("flush z later", 64'(z[0]), 64'd0);
    check_output("flush valid later", 64'(v[0]), 64'd0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 20'd2, 18'd3);
    idle(2);
    check_output("post-reset load z", 64'(z[0]), 64'd6);

    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 20'd10, 18'd10);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 20'd3, 18'd4);
    idle(5);
    check_output("hold z", 64'(z[0]), 64'd88);
    check_output("hold valid", 64'(v[0]), 64'd0);
    check_output("hold z one cycle early", 64'(z[4]), 64'd88);

    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 20'hFFFFD, 18'd5);
    idle(2);
    check_output("signed load z", 64'(z[2]), 64'(38'h3F_FFFF_FFF1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 20'hFFFFD, 18'h3FFFB);
    idle(2);
    check_output("signed sub z", 64'(z[2]), 64'(38'h3F_FFFF_FFE2));
    check_output("signed sub z one cycle early", 64'(z[5]), 64'(38'h3F_FFFF_FFE2));

    // Random traffic with operands biased toward the extremes so overflow paths get exercised.
    repeat (3000) begin
      case ($urandom_range(0, 3))
        0:       ra = 20'h7FFFF;
        1:       ra = 20'h80000;
        2:       ra = 20'hFFFFF;
        default: ra = 20'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 18'h1FFFF;
        1:       rb = 18'h20000;
        2:       rb = 18'h3FFFF;
        default: rb = 18'($urandom);
      endcase
      apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3), ra, rb);
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
